// File: rtl/alu_rr_pkg.sv
// Shared opcode constants and FSM encoding for the round-robin ALU arbiter.
package alu_rr_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_XORB = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/alu_rr_datapath.sv
// Purely combinational 4-bit function block: bypass A, bypass B, AND, ADD, SUB, XOR-reduce of B.
module alu_rr_datapath
    import alu_rr_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    input  logic [1:0] opcode_i,
    input  logic       pass_a_i,
    input  logic       pass_b_i,
    output logic [3:0] res_o,
    output logic       cout_o
);

    logic [4:0] wide;

    always_comb begin
        wide = 5'd0;
        if (pass_a_i) begin
            wide = {1'b0, a_i};
        end else if (pass_b_i) begin
            wide = {1'b0, b_i};
        end else begin
            case (opcode_i)
                OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
                // 5-bit difference: the top bit is the borrow, cin plays no part
                OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
                OP_XORB: wide = {4'b0000, ^b_i};
                default: wide = {1'b0, a_i & b_i};
            endcase
        end
    end

    assign res_o  = wide[3:0];
    assign cout_o = wide[4];

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared 4-bit ALU; grant one cycle after request, result one cycle after grant.
// Optional per-requester saturating grant counters when ALU_RR_ARBITER_STATS_EN is defined.
module alu_rr_arbiter
    import alu_rr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic       cin0,
    input  logic       cin1,
    input  logic [1:0] opcode0,
    input  logic [1:0] opcode1,
    input  logic       pass_a0,
    input  logic       pass_b0,
    input  logic       pass_a1,
    input  logic       pass_b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] out,
    output logic       cout
`ifdef ALU_RR_ARBITER_STATS_EN
    ,
    output logic [7:0] gcnt0,
    output logic [7:0] gcnt1
`endif
);

    state_t     state_q;
    logic       last_id_q, id_q;
    logic       gnt0_q, gnt1_q, rsp_valid_q, rsp_id_q, cout_q;
    logic [3:0] out_q, a_q, b_q;
    logic       cin_q, pass_a_q, pass_b_q;
    logic [1:0] opcode_q;

    logic       grant_fire, win_id;
    logic [3:0] alu_res;
    logic       alu_cout;

    // On contention the requester that did not win last time takes the slot
    assign win_id     = (req0 && req1) ? ~last_id_q : req1;
    assign grant_fire = (state_q == IDLE) && (req0 || req1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_id_q   <= 1'b1;
            id_q        <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            out_q       <= 4'd0;
            cout_q      <= 1'b0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            cin_q       <= 1'b0;
            opcode_q    <= 2'd0;
            pass_a_q    <= 1'b0;
            pass_b_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        a_q       <= win_id ? a1 : a0;
                        b_q       <= win_id ? b1 : b0;
                        cin_q     <= win_id ? cin1 : cin0;
                        opcode_q  <= win_id ? opcode1 : opcode0;
                        pass_a_q  <= win_id ? pass_a1 : pass_a0;
                        pass_b_q  <= win_id ? pass_b1 : pass_b0;
                        gnt0_q    <= ~win_id;
                        gnt1_q    <= win_id;
                        id_q      <= win_id;
                        last_id_q <= win_id;
                        state_q   <= EXEC;
                    end
                end
                default: begin
                    out_q       <= alu_res;
                    cout_q      <= alu_cout;
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    gnt0_q      <= 1'b0;
                    gnt1_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    alu_rr_datapath u_datapath (
        .a_i      (a_q),
        .b_i      (b_q),
        .cin_i    (cin_q),
        .opcode_i (opcode_q),
        .pass_a_i (pass_a_q),
        .pass_b_i (pass_b_q),
        .res_o    (alu_res),
        .cout_o   (alu_cout)
    );

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign out       = out_q;
    assign cout      = cout_q;

`ifdef ALU_RR_ARBITER_STATS_EN
    logic [7:0] gcnt0_q, gcnt1_q, gcnt0_d, gcnt1_d;

    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (grant_fire && !win_id && gcnt0_q != 8'hFF) gcnt0_d = gcnt0_q + 8'd1;
        if (grant_fire &&  win_id && gcnt1_q != 8'hFF) gcnt1_d = gcnt1_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gcnt0_q <= 8'd0;
            gcnt1_q <= 8'd0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign gcnt0 = gcnt0_q;
    assign gcnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios then randomized traffic against a transaction-level model.
module tb_alu_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       cin0, cin1;
    logic [1:0] opcode0, opcode1;
    logic       pass_a0, pass_b0, pass_a1, pass_b1;
    logic       gnt0, gnt1, rsp_valid, rsp_id, cout;
    logic [3:0] out;
`ifdef ALU_RR_ARBITER_STATS_EN
    logic [7:0] gcnt0, gcnt1;
`endif

    always #5 clk = ~clk;

    alu_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
        .opcode0(opcode0), .opcode1(opcode1),
        .pass_a0(pass_a0), .pass_b0(pass_b0), .pass_a1(pass_a1), .pass_b1(pass_b1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .out(out), .cout(cout)
`ifdef ALU_RR_ARBITER_STATS_EN
        , .gcnt0(gcnt0), .gcnt1(gcnt1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the ALU, who won last, what the result will be
    int m_busy, m_owner, m_last, m_gnt0, m_gnt1, m_rv, m_rid, m_out, m_cout;
    int p_out, p_cout, m_cnt0, m_cnt1;

    function automatic void ref_alu(input int a, input int b, input int cin, input int op,
                                    input int pa, input int pb, output int o, output int c);
        int s;
        o = 0;
        c = 0;
        if (pa != 0)      o = a;
        else if (pb != 0) o = b;
        else begin
            case (op)
                0: o = a & b;
                1: begin s = a + b + cin; o = s % 16; c = s / 16; end
                2: begin s = a - b; o = (s + 16) % 16; c = (s < 0) ? 1 : 0; end
                default: o = $countones(b) % 2;
            endcase
        end
    endfunction

    task automatic model_edge();
        int w;
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_gnt0 = 0; m_gnt1 = 0; m_rv = 0;
            m_rid = 0; m_out = 0; m_cout = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            m_rv = 0;
            if (m_busy != 0) begin
                m_rv = 1; m_rid = m_owner; m_out = p_out; m_cout = p_cout;
                m_gnt0 = 0; m_gnt1 = 0; m_busy = 0;
            end else if (req0 || req1) begin
                if (req0 && req1) w = 1 - m_last;
                else              w = req1 ? 1 : 0;
                if (w == 0) ref_alu(a0, b0, cin0, opcode0, pass_a0, pass_b0, p_out, p_cout);
                else        ref_alu(a1, b1, cin1, opcode1, pass_a1, pass_b1, p_out, p_cout);
                m_owner = w; m_last = w; m_busy = 1;
                m_gnt0 = (w == 0) ? 1 : 0;
                m_gnt1 = (w == 1) ? 1 : 0;
                if (w == 0 && m_cnt0 < 255) m_cnt0++;
                if (w == 1 && m_cnt1 < 255) m_cnt1++;
            end else begin
                m_gnt0 = 0; m_gnt1 = 0;
            end
        end
    endtask

    // Inputs are set at the negedge; step through one rising edge and compare everything
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("gnt0", 8'(gnt0), 8'(m_gnt0));
        chk("gnt1", 8'(gnt1), 8'(m_gnt1));
        chk("rsp_valid", 8'(rsp_valid), 8'(m_rv));
        chk("rsp_id", 8'(rsp_id), 8'(m_rid));
        chk("out", 8'(out), 8'(m_out));
        chk("cout", 8'(cout), 8'(m_cout));
`ifdef ALU_RR_ARBITER_STATS_EN
        chk("gcnt0", gcnt0, 8'(m_cnt0));
        chk("gcnt1", gcnt1, 8'(m_cnt1));
`endif
    endtask

    task automatic set0(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [1:0] op, input logic pa, input logic pb);
        a0 = a; b0 = b; cin0 = c; opcode0 = op; pass_a0 = pa; pass_b0 = pb;
    endtask

    task automatic set1(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [1:0] op, input logic pa, input logic pb);
        a1 = a; b1 = b; cin1 = c; opcode1 = op; pass_a1 = pa; pass_b1 = pb;
    endtask

    task automatic rand0();
        set0(4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    endtask

    task automatic rand1();
        set1(4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    endtask

    int seq[$];

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0;
        set0(4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        set1(4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held with req0 high
        cycle();
        cycle();
        chk("rst_gnt0", 8'(gnt0), 8'h0);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'h0);
        chk("rst_out", 8'(out), 8'h0);
        chk("rst_cout", 8'(cout), 8'h0);

        // Single add: F + 1 + 1
        rst_n = 1'b1;
        set0(4'hF, 4'h1, 1'b1, 2'b01, 1'b0, 1'b0);
        cycle();
        chk("first_gnt0", 8'(gnt0), 8'h1);
        req0 = 1'b0;
        set0(4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        cycle();
        chk("add_valid", 8'(rsp_valid), 8'h1);
        chk("add_id", 8'(rsp_id), 8'h0);
        chk("add_out", 8'(out), 8'h1);
        chk("add_cout", 8'(cout), 8'h1);

        // Bypass priority: pass_a beats pass_b and the opcode
        req1 = 1'b1;
        set1(4'h5, 4'hA, 1'b0, 2'b01, 1'b1, 1'b1);
        cycle();
        req1 = 1'b0;
        cycle();
        chk("byp_out", 8'(out), 8'h5);
        chk("byp_cout", 8'(cout), 8'h0);
        chk("byp_id", 8'(rsp_id), 8'h1);

        // Subtract with borrow
        req0 = 1'b1;
        set0(4'h3, 4'h5, 1'b1, 2'b10, 1'b0, 1'b0);
        cycle();
        req0 = 1'b0;
        cycle();
        chk("sub_out", 8'(out), 8'hE);
        chk("sub_cout", 8'(cout), 8'h1);

        // XOR-reduce of B
        req1 = 1'b1;
        set1(4'h9, 4'b0111, 1'b1, 2'b11, 1'b0, 1'b0);
        cycle();
        req1 = 1'b0;
        cycle();
        chk("xorb_out", 8'(out), 8'h1);
        chk("xorb_cout", 8'(cout), 8'h0);

        // Continuous contention: grants must alternate starting with requester 0
        req0 = 1'b1; req1 = 1'b1;
        rand0(); rand1();
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (gnt0) seq.push_back(0);
            if (gnt1) seq.push_back(1);
        end
        req0 = 1'b0; req1 = 1'b0;
        cycle();
        chk("cont_count", 8'(seq.size()), 8'd4);
        foreach (seq[i]) chk("cont_order", 8'(seq[i]), 8'(i % 2));

        // Reset while the ALU is busy for requester 1
        req1 = 1'b1;
        cycle();
        chk("pre_rst_gnt1", 8'(gnt1), 8'h1);
        req1 = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_exec_valid", 8'(rsp_valid), 8'h0);
        chk("rst_exec_out", 8'(out), 8'h0);
        req0 = 1'b1; req1 = 1'b1;
        cycle();
        chk("post_rst_gnt0", 8'(gnt0), 8'h1);
        req0 = 1'b0; req1 = 1'b0;
        cycle();

        // Random traffic obeying the requester protocol, with rare resets
        for (int i = 0; i < 600; i++) begin
            if (m_gnt0 != 0) begin req0 = 1'b0; rand0(); end
            else if (!req0 && $urandom_range(0, 1) == 1) begin req0 = 1'b1; rand0(); end
            if (m_gnt1 != 0) begin req1 = 1'b0; rand1(); end
            else if (!req1 && $urandom_range(0, 1) == 1) begin req1 = 1'b1; rand1(); end
            rst_n = ($urandom_range(0, 59) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
